vector_exec_unit: RTL and testbench

//  Multi-cycle SIMD execute stage downstream of the vector register file.

---
 rtl/vector_exec_unit.sv | 156 +++++++++++++++
 tb/tb_vector_exec_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vector_exec_unit.sv
// Multi-cycle SIMD execute stage: captures two VLEN-bit operands, processes SLICE_W bits
// per beat with lane-wise arithmetic, then issues a single register-file write-back.
module vector_exec_unit #(
    parameter int unsigned VLEN    = 256,
    parameter int unsigned SLICE_W = 64,
    parameter int unsigned RD_W    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [1:0]      esize,
    input  logic [RD_W-1:0] rd,
    input  logic [VLEN-1:0] busA,
    input  logic [VLEN-1:0] busB,
    output logic            busy,
    output logic            done,
    output logic            RegWrite,
    output logic [RD_W-1:0] RW,
    output logic [VLEN-1:0] busW
);
    localparam int unsigned NBEATS = VLEN / SLICE_W;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned NCHUNK = SLICE_W / 64;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MINU, OP_MAXU, OP_ADDSU
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [1:0]        esize_q, esize_d;
    logic [RD_W-1:0]   rd_q, rd_d, rw_q, rw_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [VLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d, busw_q, busw_d;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_res;

    // Operands arrive zero-extended to 64 bits; mask selects the element width.
    function automatic logic [63:0] elem_op(input op_e o, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] mask);
        logic [64:0] sum;
        logic [63:0] r;
        sum = {1'b0, a} + {1'b0, b};
        case (o)
            OP_ADD:   r = sum[63:0] & mask;
            OP_SUB:   r = (a - b) & mask;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_MINU:  r = (a < b) ? a : b;
            OP_MAXU:  r = (a > b) ? a : b;
            OP_ADDSU: r = (sum > {1'b0, mask}) ? mask : sum[63:0];
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] op64(input op_e o, input logic [1:0] es,
                                         input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        case (es)
            2'b00: for (int unsigned i = 0; i < 8; i++) begin
                t = elem_op(o, {56'b0, a[i*8 +: 8]}, {56'b0, b[i*8 +: 8]}, 64'hFF);
                r[i*8 +: 8] = t[7:0];
            end
            2'b01: for (int unsigned i = 0; i < 4; i++) begin
                t = elem_op(o, {48'b0, a[i*16 +: 16]}, {48'b0, b[i*16 +: 16]}, 64'hFFFF);
                r[i*16 +: 16] = t[15:0];
            end
            2'b10: for (int unsigned i = 0; i < 2; i++) begin
                t = elem_op(o, {32'b0, a[i*32 +: 32]}, {32'b0, b[i*32 +: 32]}, 64'hFFFF_FFFF);
                r[i*32 +: 32] = t[31:0];
            end
            default: r = elem_op(o, a, b, '1);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        esize_d   = esize_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        beat_d    = beat_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        busw_d    = busw_q;
        slice_a   = a_q[beat_q*SLICE_W +: SLICE_W];
        slice_b   = b_q[beat_q*SLICE_W +: SLICE_W];
        slice_res = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            slice_res[k*64 +: 64] = op64(op_q, esize_q, slice_a[k*64 +: 64], slice_b[k*64 +: 64]);
        end
        case (state_q)
            IDLE: if (start) begin
                state_d  = EXEC;
                op_d     = op_e'(op);
                esize_d  = esize;
                rd_d     = rd;
                a_d      = busA;
                b_d      = busB;
                beat_d   = '0;
                result_d = '0;
            end
            EXEC: begin
                result_d[beat_q*SLICE_W +: SLICE_W] = slice_res;
                beat_d = beat_q + 1'b1;
                // Write-back registers load on the final beat so they hold between ops.
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    state_d = WB;
                    beat_d  = '0;
                    busw_d  = result_d;
                    rw_d    = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            esize_q  <= '0;
            rd_q     <= '0;
            rw_q     <= '0;
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busw_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            esize_q  <= esize_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            beat_q   <= beat_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            busw_q   <= busw_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == WB);
    assign RegWrite = done && (rd_q != RD_W'(3));
    assign RW       = rw_q;
    assign busW     = busw_q;
endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit with hand-computed expected values.
module tb_vector_exec_unit;
    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [1:0]   esize, rd, RW;
    logic [255:0] busA, busB, busW;
    logic         busy, done, RegWrite;
    int checks = 0;
    int failures = 0;
    int lat, wlat, nwr, ndone, bsy;

    vector_exec_unit #(.VLEN(256), .SLICE_W(64), .RD_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .esize(esize), .rd(rd),
        .busA(busA), .busB(busB), .busy(busy), .done(done), .RegWrite(RegWrite),
        .RW(RW), .busW(busW)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one op, then watches a fixed 12-cycle window after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [1:0] es, input logic [1:0] r,
                          input logic [255:0] a, input logic [255:0] b,
                          output int l, output int wl, output int nw, output int nd, output int bz);
        op = o; esize = es; rd = r; busA = a; busB = b; start = 1'b1;
        tick();
        start = 1'b0;
        bz = int'(busy);
        l = 0; wl = 0; nw = 0; nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin nd++; if (l == 0) l = i + 1; end
            if (RegWrite) begin nw++; if (wl == 0) wl = i + 1; end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; esize = '0; rd = '0; busA = '0; busB = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_rw", RW, 0);
        check("rst_busw", busW, 0);

        // 1: byte ADD, no carry across byte lanes
        run_op(3'b000, 2'b00, 2'd1, {32{8'hFF}}, {32{8'h01}}, lat, wlat, nwr, ndone, bsy);
        check("t1_busy_after_accept", 256'(bsy), 1);
        check("t1_done_latency", 256'(lat), 4);
        check("t1_wr_latency", 256'(wlat), 4);
        check("t1_wr_count", 256'(nwr), 1);
        check("t1_done_count", 256'(ndone), 1);
        check("t1_busw", busW, '0);
        check("t1_rw", RW, 1);
        check("t1_idle", busy, 0);

        // 2: SUB 32-bit wraps; ADDSU 16-bit saturates
        run_op(3'b001, 2'b10, 2'd2, '0, {8{32'h0000_0001}}, lat, wlat, nwr, ndone, bsy);
        check("t2_sub_busw", busW, {8{32'hFFFF_FFFF}});
        check("t2_sub_rw", RW, 2);
        run_op(3'b111, 2'b01, 2'd0, 256'h0001_FFF0, 256'h0001_0020, lat, wlat, nwr, ndone, bsy);
        check("t2_addsu_busw", busW, 256'h0002_FFFF);
        check("t2_addsu_wr_count", 256'(nwr), 1);

        // 3: operands captured at accept; starts during EXEC/WB ignored
        op = 3'b000; esize = 2'b11; rd = 2'd2; start = 1'b1;
        busA = {64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h1000_0000_0000_0000};
        busB = {4{64'h1111_1111_1111_1111}};
        tick();
        op = 3'b100; busA = {4{64'hDEAD_BEEF_0BAD_F00D}}; busB = '0;
        nwr = 0; ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (RegWrite) nwr++;
            if (done) ndone++;
        end
        check("t3_idle_after_wb_start", busy, 0);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RegWrite) nwr++;
            if (done) ndone++;
        end
        check("t3_wr_count", 256'(nwr), 1);
        check("t3_done_count", 256'(ndone), 1);
        check("t3_busw", busW, {64'h1234_5678_9ABC_DF00, 64'h1111_1111_1111_1112,
                                64'h1111_1111_1111_1110, 64'h2111_1111_1111_1111});

        // 4: reset during beat 2 aborts the op
        op = 3'b000; esize = 2'b00; rd = 2'd1; busA = {32{8'h05}}; busB = {32{8'h03}};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_busy_after_reset", busy, 0);
        check("t4_busw_zeroed", busW, '0);
        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (RegWrite || done) nwr++;
        end
        check("t4_no_wb_after_abort", 256'(nwr), 0);
        run_op(3'b000, 2'b00, 2'd1, {32{8'h05}}, {32{8'h03}}, lat, wlat, nwr, ndone, bsy);
        check("t4_restart_busw", busW, {32{8'h08}});
        check("t4_restart_latency", 256'(lat), 4);

        // 5: unsigned MIN/MAX on 64-bit lanes
        run_op(3'b101, 2'b11, 2'd0, {{2{64'h8000_0000_0000_0000}}, {2{64'h1}}},
               {{2{64'h1}}, {2{64'h8000_0000_0000_0000}}}, lat, wlat, nwr, ndone, bsy);
        check("t5_minu", busW, {4{64'h1}});
        run_op(3'b110, 2'b11, 2'd0, {{2{64'h8000_0000_0000_0000}}, {2{64'h1}}},
               {{2{64'h1}}, {2{64'h8000_0000_0000_0000}}}, lat, wlat, nwr, ndone, bsy);
        check("t5_maxu", busW, {4{64'h8000_0000_0000_0000}});

        // Logic op, element size ignored
        run_op(3'b100, 2'b10, 2'd2, {32{8'hF0}}, {16{16'hFF00}}, lat, wlat, nwr, ndone, bsy);
        check("xor_busw", busW, {16{16'h0FF0}});

        // 6: rd==3 executes but never writes the register file
        run_op(3'b010, 2'b00, 2'd3, {32{8'hAA}}, {32{8'h0F}}, lat, wlat, nwr, ndone, bsy);
        check("t6_done_latency", 256'(lat), 4);
        check("t6_done_count", 256'(ndone), 1);
        check("t6_wr_count", 256'(nwr), 0);
        check("t6_busw", busW, {32{8'h0A}});
        check("t6_rw", RW, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
